// File: rtl/mux2_arb_stage.sv
// Two-channel valid/ready arbiter feeding a one-entry output register; s drives the downstream 2:1 mux.
// Define MUX2_ARB_FIXED_PRIO_EN for fixed channel-0 priority instead of round-robin.
//
// state | meaning
// EMPTY | output register holds no valid data
// FULL  | output register holds data awaiting y_ready
module mux2_arb_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] d1,
  input  logic             v1,
  output logic             r1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             g;
  logic             space;
  logic             xfer;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  always_comb begin
    g = v1 && !v0;
  end
`else
  logic last_q, last_d;

  // Contention alternates; an idle cycle keeps the select parked on the last winner.
  always_comb begin
    g = last_q;
    if (v0 && v1) g = !last_q;
    else if (v0)  g = 1'b0;
    else if (v1)  g = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (xfer) last_d = g;
  end
`endif

  always_comb begin
    space = (state_q == EMPTY) || y_ready;
    r0    = !rst && space && v0 && !g;
    r1    = !rst && space && v1 && g;
    s     = !rst && g;
    xfer  = (r0 && v0) || (r1 && v1);
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    if (xfer) begin
      y_d     = g ? d1 : d0;
      state_d = FULL;
    end else if (y_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y       = y_q;
  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux2_arb_stage.sv
// Directed bench for mux2_arb_stage: reset, streaming, contention, backpressure, drain, mid-run reset.
// Expectations follow MUX2_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_mux2_arb_stage;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1, y;
  logic       v0, v1, r0, r1, s, y_valid, y_ready;

  int n_cmp = 0;
  int n_err = 0;

  mux2_arb_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .d0(d0), .v0(v0), .r0(r0),
    .d1(d1), .v1(v1), .r1(r1),
    .s(s), .y(y), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_g;
    logic [7:0] exp_y;

    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; y_ready = 1'b1;
    #1;
    chk("rst_r0", {31'd0, r0}, 0);
    chk("rst_r1", {31'd0, r1}, 0);
    chk("rst_s", {31'd0, s}, 0);
    chk("rst_y", {24'd0, y}, 32'h00);
    chk("rst_yv", {31'd0, y_valid}, 0);
    tick(); tick();
    rst = 1'b0;

    // Contention from reset: channel 0 wins first, then alternates (fixed: always 0).
    for (int i = 0; i < 5; i++) begin
      exp_g = FIXED ? 1'b0 : i[0];
      exp_y = exp_g ? 8'h22 : 8'h11;
      #1;
      chk("cont_s", {31'd0, s}, {31'd0, exp_g});
      chk("cont_r_excl", {31'd0, r0 & r1}, 0);
      chk("cont_r1", {31'd0, r1}, {31'd0, exp_g});
      tick();
      chk("cont_y", {24'd0, y}, {24'd0, exp_y});
      chk("cont_yv", {31'd0, y_valid}, 1);
    end

    // Backpressure with y=11 held; pending grant goes to channel 1 next.
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_r0", {31'd0, r0}, 0);
      chk("bp_r1", {31'd0, r1}, 0);
      chk("bp_s", {31'd0, s}, FIXED ? 32'd0 : 32'd1);
      tick();
      chk("bp_y", {24'd0, y}, 32'h11);
      chk("bp_yv", {31'd0, y_valid}, 1);
    end
    y_ready = 1'b1;
    #1;
    chk("bp_rel_r1", {31'd0, r1}, FIXED ? 32'd0 : 32'd1);
    tick();
    chk("bp_rel_y", {24'd0, y}, FIXED ? 32'h11 : 32'h22);

    // Single channel 0 then back-to-back stream.
    v1 = 1'b0; d0 = 8'hA5;
    #1;
    chk("single_s", {31'd0, s}, 0);
    chk("single_r0", {31'd0, r0}, 1);
    tick();
    chk("single_y", {24'd0, y}, 32'hA5);
    chk("single_yv", {31'd0, y_valid}, 1);
    for (int i = 1; i <= 4; i++) begin
      d0 = 8'(i);
      tick();
      chk("stream_y", {24'd0, y}, i);
      chk("stream_yv", {31'd0, y_valid}, 1);
    end

    // Drain without refill; select parks on the last winner (channel 0).
    v0 = 1'b0;
    #1;
    chk("drain_s", {31'd0, s}, 0);
    tick();
    chk("drain_yv", {31'd0, y_valid}, 0);
    chk("drain_y", {24'd0, y}, 32'h04);

    // Channel 1 alone while empty, with y_ready low: still accepted.
    v1 = 1'b1; d1 = 8'h77; y_ready = 1'b0;
    #1;
    chk("solo1_s", {31'd0, s}, 1);
    chk("solo1_r1", {31'd0, r1}, 1);
    tick();
    chk("solo1_y", {24'd0, y}, 32'h77);
    v1 = 1'b0;
    tick();
    chk("hold_y", {24'd0, y}, 32'h77);
    chk("hold_yv", {31'd0, y_valid}, 1);

    // Mid-cycle asynchronous reset with valid data pending.
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_y", {24'd0, y}, 32'h00);
    chk("mrst_yv", {31'd0, y_valid}, 0);
    chk("mrst_s", {31'd0, s}, 0);
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h33; d1 = 8'h44; y_ready = 1'b1;
    #1;
    chk("mrst_r0", {31'd0, r0}, 0);
    chk("mrst_r1", {31'd0, r1}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_r0", {31'd0, r0}, 1);
    tick();
    chk("post_rst_y", {24'd0, y}, 32'h33);
    tick();
    chk("post_rst_y2", {24'd0, y}, FIXED ? 32'h33 : 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
